// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader for the instruction memory: assembles little-endian words,
// writes them from word 0 upward, holds the core meanwhile and restarts it afterwards.
module imem_boot_loader #(
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 64,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W:0]   word_count_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              cpu_restart_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       shift_q;
  logic [TMR_W-1:0]  timer_q;
  logic              err_q;

  logic              count_ok;
  logic [ADDR_W:0]   ptr_inc;
  logic              transfer;

  assign count_ok = (word_count_i != '0) && (word_count_i <= (ADDR_W+1)'(DEPTH));
  assign ptr_inc  = {1'b0, ptr_q} + (ADDR_W+1)'(1);
  assign transfer = (state_q == S_LOAD) && byte_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      ptr_q      <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start_i) begin
            if (count_ok) begin
              state_q    <= S_LOAD;
              count_q    <= word_count_i;
              ptr_q      <= '0;
              byte_cnt_q <= '0;
              timer_q    <= '0;
              err_q      <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (transfer) begin
            shift_q[{byte_cnt_q, 3'b000} +: 8] <= byte_data_i;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            timer_q    <= '0;
            if (byte_cnt_q == 2'd3) state_q <= S_WRITE;
          end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_WRITE: begin
          // ptr wraps to 0 after the last word of a full-depth load
          ptr_q      <= ptr_inc[ADDR_W-1:0];
          byte_cnt_q <= '0;
          timer_q    <= '0;
          state_q    <= (ptr_inc == count_q) ? S_DONE : S_LOAD;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready_o  = (state_q == S_LOAD);
  assign mem_we_o      = (state_q == S_WRITE);
  assign mem_wdata_o   = shift_q;
  assign mem_addr_o    = (state_q == S_IDLE) ? fetch_addr_i : ptr_q;
  assign cpu_hold_o    = (state_q != S_IDLE);
  assign cpu_restart_o = (state_q == S_DONE);
  assign done_o        = (state_q == S_DONE);
  assign busy_o        = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign err_o         = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised scoreboard bench for imem_boot_loader: expected writes are queued by the
// stimulus and popped by a negedge monitor whenever the loader writes or signals done.
module tb_imem_boot_loader;

  localparam int AW  = 6;
  localparam int DEP = 64;
  localparam int TO  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   wc = '0;
  logic          bv = 1'b0;
  logic [7:0]    bd = '0;
  logic          br;
  logic [AW-1:0] fa = 6'h15;
  logic [AW-1:0] ma;
  logic          we;
  logic [31:0]   wd;
  logic          hold, restart, busy, done, err;

  imem_boot_loader #(.ADDR_W(AW), .DEPTH(DEP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .word_count_i(wc),
    .byte_valid_i(bv), .byte_data_i(bd), .byte_ready_o(br), .fetch_addr_i(fa),
    .mem_addr_o(ma), .mem_we_o(we), .mem_wdata_o(wd), .cpu_hold_o(hold),
    .cpu_restart_o(restart), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  last_wr = -10;
  bit  done_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue, in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(ma), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", 32'(ma), 32'(e.a));
          chk("write_data", wd, e.d);
          last_wr = cyc;
        end
      end
      if (done || restart) begin
        chk("done_expected", 32'(done_exp), 32'd1);
        chk("restart_with_done", 32'(restart), 32'(done));
        chk("hold_in_done", 32'(hold), 32'd1);
        chk("no_we_in_done", 32'(we), 32'd0);
        chk("all_writes_before_done", 32'(exp_q.size()), 32'd0);
        chk("done_latency", 32'(cyc), 32'(last_wr + 1));
        done_exp = 1'b0;
      end
    end
  end

  task automatic pulse_start(input int n);
    start = 1'b1;
    wc    = (AW+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    bit ok;
    bv = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bv = 1'b1;
    bd = b;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      got = br;
      @(posedge clk); #1;
      if (got) ok = 1'b1;
    end
    bv = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input int a, input logic [31:0] w, input int maxgap);
    exp_q.push_back('{a: AW'(a), d: w});
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 200 && done_exp; t++) begin @(posedge clk); #1; end
    if (done_exp) begin
      chk("done_timeout", 32'd0, 32'd1);
      done_exp = 1'b0;
    end
  endtask

  task automatic load(input int n, input int maxgap);
    pulse_start(n);
    done_exp = 1'b1;
    for (int i = 0; i < n; i++) send_word(i, $urandom, maxgap);
    wait_done();
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_hold"}, 32'(hold), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_addr_mux"}, 32'(ma), 32'(fa));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(br), 32'd0);
    chk({tag, "_we"}, 32'(we), 32'd0);
    chk({tag, "_wdata"}, wd, 32'd0);
    chk({tag, "_hold"}, 32'(hold), 32'd0);
    chk({tag, "_restart"}, 32'(restart), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_addr"}, 32'(ma), 32'h15);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    fa = 6'h2A; #1;
    chk("rst_addr_follows_fetch", 32'(ma), 32'h2A);
    fa = 6'h15;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted in the middle of a byte stream
    pulse_start(3);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    bv = 1'b1; bd = 8'h33;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    bv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word directed load
    pulse_start(2);
    done_exp = 1'b1;
    exp_q.push_back('{a: 6'd0, d: 32'h0000_0013});
    exp_q.push_back('{a: 6'd1, d: 32'h0040_2083});
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h83, 0); send_byte(8'h20, 0); send_byte(8'h40, 0); send_byte(8'h00, 0);
    wait_done();
    check_idle("after_two");

    // Full-depth load with random gaps shorter than the timeout
    load(DEP, 5);
    check_idle("after_full");

    // Out-of-range word counts
    pulse_start(0);
    @(negedge clk);
    chk("wc0_err", 32'(err), 32'd1);
    chk("wc0_hold", 32'(hold), 32'd1);
    chk("wc0_ready", 32'(br), 32'd0);
    @(posedge clk); #1;
    pulse_start(DEP + 1);
    @(negedge clk);
    chk("wc65_err", 32'(err), 32'd1);
    chk("wc65_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    pulse_start(1);
    done_exp = 1'b1;
    @(negedge clk);
    chk("restart_clears_err", 32'(err), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    send_word(0, $urandom, 0);
    wait_done();

    // Timeout: two bytes then silence
    pulse_start(1);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 1);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      chk($sformatf("timeout_still_loading_%0d", i), 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_ready", 32'(br), 32'd0);
    chk("timeout_hold", 32'(hold), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // start during LOAD is ignored
    pulse_start(2);
    done_exp = 1'b1;
    send_word(0, $urandom, 2);
    pulse_start(7);
    @(negedge clk);
    chk("start_in_load_busy", 32'(busy), 32'd1);
    chk("start_in_load_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    send_word(1, $urandom, 2);
    wait_done();

    // byte_valid held in IDLE is not consumed
    bv = 1'b1; bd = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_ready_low", 32'(br), 32'd0);
      @(posedge clk); #1;
    end
    bv = 1'b0;
    load(3, 3);
    check_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
